// File: rtl/hbridge_gate_driver.sv
// Full H-bridge gate driver with an all-off dead time on every exit from a drive state.
// Optional PWM chopping of the active high-side gate when HBRIDGE_PWM_EN is defined.
module hbridge_gate_driver #(
    parameter int DEAD_CYCLES = 4,
    parameter int PWM_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       cmd,
`ifdef HBRIDGE_PWM_EN
    input  logic [PWM_W-1:0] duty,
`endif
    output logic             hs_a,
    output logic             ls_a,
    output logic             hs_b,
    output logic             ls_b,
    output logic             busy,
    output logic             fault
);

    localparam int CNT_W = $clog2(DEAD_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);

    typedef enum logic [1:0] {S_OFF, S_CW, S_CCW, S_DEAD} state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             fault_d;
    logic             hi_on;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_OFF;
            cnt   <= '0;
            fault <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            fault <= fault_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        fault_d = fault;
        if (cmd == 2'b11)
            fault_d = 1'b1;
        else if (state == S_OFF && cmd == 2'b00)
            fault_d = 1'b0;
        case (state)
            S_OFF: begin
                // a latched fault blocks any new drive until stop is seen in OFF
                if (!fault) begin
                    if (cmd == 2'b01)      state_d = S_CW;
                    else if (cmd == 2'b10) state_d = S_CCW;
                end
            end
            S_CW: begin
                if (cmd != 2'b01) begin
                    state_d = S_DEAD;
                    cnt_d   = DEAD_LOAD;
                end
            end
            S_CCW: begin
                if (cmd != 2'b10) begin
                    state_d = S_DEAD;
                    cnt_d   = DEAD_LOAD;
                end
            end
            S_DEAD: begin
                if (cnt == '0) begin
                    if (!fault && cmd == 2'b01)      state_d = S_CW;
                    else if (!fault && cmd == 2'b10) state_d = S_CCW;
                    else                             state_d = S_OFF;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            default: state_d = S_OFF;
        endcase
    end

`ifdef HBRIDGE_PWM_EN
    logic [PWM_W-1:0] pwm_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pwm_cnt <= '0;
        else     pwm_cnt <= pwm_cnt + PWM_W'(1);
    end

    assign hi_on = (pwm_cnt < duty);
`else
    assign hi_on = 1'b1;
`endif

    // low side stays on through the PWM off-time (slow decay)
    assign hs_a = (state == S_CW)  & hi_on;
    assign ls_b = (state == S_CW);
    assign hs_b = (state == S_CCW) & hi_on;
    assign ls_a = (state == S_CCW);
    assign busy = (state == S_DEAD);

    a_no_shoot: assert property (@(posedge clk) disable iff (rst)
        !(hs_a && ls_a) && !(hs_b && ls_b));

endmodule

// File: tb/tb_hbridge_gate_driver.sv
// Randomized scoreboard bench for hbridge_gate_driver against a direction/countdown model.
module tb_hbridge_gate_driver;

    localparam int DEAD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] cmd = 2'b00;
    logic       hs_a, ls_a, hs_b, ls_b, busy, fault;
`ifdef HBRIDGE_PWM_EN
    logic [7:0] duty = 8'd0;
`endif

    hbridge_gate_driver #(.DEAD_CYCLES(DEAD), .PWM_W(8)) dut (
        .clk(clk), .rst(rst), .cmd(cmd),
`ifdef HBRIDGE_PWM_EN
        .duty(duty),
`endif
        .hs_a(hs_a), .ls_a(ls_a), .hs_b(hs_b), .ls_b(ls_b),
        .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [5:0] exp_q[$];

    // model: direction 0 none / 1 CW / 2 CCW, remaining dead cycles, fault, pwm phase
    int m_dir = 0;
    int m_dead = 0;
    bit m_fault = 0;
    int m_pwm = 0;

    function automatic logic [5:0] outs();
        return {hs_a, ls_a, hs_b, ls_b, busy, fault};
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s t=%0t got {hsa,lsa,hsb,lsb,busy,fault}=%b want %b", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        m_dir = 0; m_dead = 0; m_fault = 0; m_pwm = 0;
    endtask

    task automatic model_step(input logic [1:0] c);
        bit f_old;
        int d;
        bit hs_on;
        f_old = m_fault;
        d = int'(c);
        if (d == 3) m_fault = 1;
        else if (m_dead == 0 && m_dir == 0 && d == 0) m_fault = 0;
        if (m_dead > 0) begin
            if (m_dead == 1) begin
                m_dead = 0;
                m_dir = (f_old || d == 0 || d == 3) ? 0 : d;
            end else m_dead--;
        end else if (m_dir == 0) begin
            if (!f_old && (d == 1 || d == 2)) m_dir = d;
        end else if (d != m_dir) begin
            m_dir = 0;
            m_dead = DEAD;
        end
        m_pwm = (m_pwm + 1) % 256;
`ifdef HBRIDGE_PWM_EN
        hs_on = (m_pwm < int'(duty));
`else
        hs_on = 1'b1;
`endif
        exp_q.push_back({m_dir == 1 && hs_on, m_dir == 2, m_dir == 2 && hs_on,
                         m_dir == 1, m_dead > 0, m_fault});
    endtask

    // called at a negedge; applies cmd for n cycles, ends at a negedge
    task automatic drive(input logic [1:0] c, input int n);
        for (int i = 0; i < n; i++) begin
            cmd = c;
            model_step(c);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        int waitc;
        waitc = 0;
        while (exp_q.size() != 0 && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout queue=%0d", exp_q.size());
            exp_q.delete();
        end
        #2 rst = 1'b1;
        #1 check("async_reset", outs(), 6'b000000);
        cmd = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("reset_hold", outs(), 6'b000000);
        rst = 1'b0;
        model_reset();
    endtask

    // monitor: every rising edge the DUT presents one new output vector
    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            logic [5:0] e;
            e = exp_q.pop_front();
            check("gates", outs(), e);
            n_cmp++;
            if ((hs_a && ls_a) || (hs_b && ls_b)) begin
                n_err++;
                $display("FAIL shoot_through t=%0t got %b want no hs&ls", $time, outs());
            end
        end
    end

    initial begin
        #1 check("reset_state", outs(), 6'b000000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
`ifdef HBRIDGE_PWM_EN
        duty = 8'd255;
`endif
        // reset mid-CW, then restart
        drive(2'b01, 5);
        do_reset();
        drive(2'b01, 3);
        // CW -> CCW reversal
        drive(2'b10, 8);
        // reset mid-DEAD
        drive(2'b01, 2);
        do_reset();
        // fault path
        drive(2'b01, 3);
        drive(2'b11, 1);
        drive(2'b00, 4);
        drive(2'b01, 3);
        drive(2'b00, 1);
        drive(2'b01, 3);
        // one-cycle stop glitch in CW
        drive(2'b00, 1);
        drive(2'b01, 7);
        // toggle during DEAD, exit to whichever cmd is present
        for (int i = 0; i < 9; i++) drive(i[0] ? 2'b01 : 2'b10, 1);
        drive(2'b00, 6);
        // fault set and cleared on consecutive edges in OFF
        drive(2'b11, 1);
        drive(2'b00, 1);
        drive(2'b01, 2);
`ifdef HBRIDGE_PWM_EN
        duty = 8'd64;
        drive(2'b01, 600);
        duty = 8'd0;
        drive(2'b01, 300);
        duty = 8'd255;
        drive(2'b01, 300);
`endif
        for (int k = 0; k < 200; k++) begin
            logic [1:0] c;
            int r;
            r = $urandom_range(0, 9);
            c = (r < 2) ? 2'b00 : (r < 5) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
`ifdef HBRIDGE_PWM_EN
            duty = 8'($urandom_range(0, 255));
`endif
            drive(c, $urandom_range(1, 12));
            if (k == 100) do_reset();
        end
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL final_drain queue=%0d", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
